// File: rtl/muldiv_sched_if.sv
`default_nettype none
// muldiv_sched_if: request/operand/result bundle between the two execute slots and muldiv_sched.
interface muldiv_sched_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            req0_i;
  logic [2:0]      op0_i;
  logic [XLEN-1:0] a0_i;
  logic [XLEN-1:0] b0_i;
  logic            req1_i;
  logic [2:0]      op1_i;
  logic [XLEN-1:0] a1_i;
  logic [XLEN-1:0] b1_i;
  logic            stall_o;
  logic            done0_o;
  logic [XLEN-1:0] result0_o;
  logic            done1_o;
  logic [XLEN-1:0] result1_o;

  modport master (
    output flush_i, req0_i, op0_i, a0_i, b0_i, req1_i, op1_i, a1_i, b1_i,
    input  stall_o, done0_o, result0_o, done1_o, result1_o
  );

  modport slave (
    input  flush_i, req0_i, op0_i, a0_i, b0_i, req1_i, op1_i, a1_i, b1_i,
    output stall_o, done0_o, result0_o, done1_o, result1_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// muldiv_sched: one iterative RV32M mul/div engine shared by two execute slots, slot 0 first.
// Rev 1.0
module muldiv_sched #(
  parameter int XLEN = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  muldiv_sched_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [1:0]        served;
  logic [CW-1:0]     count;
  logic              owner;
  logic [2:0]        op;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opnd;
  logic              neg_res;
  logic              neg_rem;
  logic              b_zero;
  logic [1:0]        done;
  logic [XLEN-1:0]   result0;
  logic [XLEN-1:0]   result1;

  logic [1:0]        req;
  logic              pick0;
  logic              pick1;
  logic [2:0]        sel_op;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  assign req           = {bus.req1_i, bus.req0_i};
  assign bus.stall_o   = |(req & ~served);
  assign bus.done0_o   = done[0];
  assign bus.done1_o   = done[1];
  assign bus.result0_o = result0;
  assign bus.result1_o = result1;

  assign pick0 = req[0] & ~served[0];
  assign pick1 = req[1] & ~served[1];

  always_comb begin
    sel_op = pick0 ? bus.op0_i : bus.op1_i;
    sel_a  = pick0 ? bus.a0_i  : bus.a1_i;
    sel_b  = pick0 ? bus.b0_i  : bus.b1_i;
    // MUL low half is sign-agnostic, so only MULH/MULHSU/DIV/REM take magnitudes
    a_neg  = (sel_op inside {3'd1, 3'd2, 3'd4, 3'd6}) & sel_a[XLEN-1];
    b_neg  = (sel_op inside {3'd1, 3'd4, 3'd6}) & sel_b[XLEN-1];
  end

  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_sh   = {acc, lo[XLEN-1]};
    div_ge   = div_sh >= {1'b0, opnd};
    div_diff = div_sh[XLEN-1:0] - opnd;
  end

  always_comb begin
    prod = neg_res ? -{acc, lo} : {acc, lo};
    // Divide-by-zero keeps the all-ones quotient regardless of dividend sign
    quo  = (neg_res & ~b_zero) ? -lo : lo;
    rem  = neg_rem ? -acc : acc;
    case (op)
      3'd0:                fix_val = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_val = quo;
      default:             fix_val = rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      served  <= 2'b00;
      count   <= '0;
      owner   <= 1'b0;
      op      <= 3'd0;
      acc     <= '0;
      lo      <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      done    <= 2'b00;
      result0 <= '0;
      result1 <= '0;
    end else begin
      done <= 2'b00;
      if (bus.flush_i) begin
        state  <= IDLE;
        served <= 2'b00;
        count  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pick0 | pick1) begin
              owner   <= ~pick0;
              op      <= sel_op;
              acc     <= '0;
              lo      <= a_neg ? -sel_a : sel_a;
              opnd    <= b_neg ? -sel_b : sel_b;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              b_zero  <= (sel_b == '0);
              count   <= '0;
              state   <= CALC;
            end
          end
          CALC: begin
            if (op[2]) begin
              acc <= div_ge ? div_diff : div_sh[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], div_ge};
            end else begin
              acc <= mul_sum[XLEN:1];
              lo  <= {mul_sum[0], lo[XLEN-1:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(XLEN - 1)) state <= FIX;
          end
          FIX: begin
            if (owner) result1 <= fix_val;
            else       result0 <= fix_val;
            done[owner]   <= 1'b1;
            served[owner] <= 1'b1;
            state         <= DONE;
          end
          default: state <= IDLE;
        endcase
        // A stall-free cycle means the pair has advanced; start the next one clean
        if (!bus.stall_o) served <= 2'b00;
      end
    end
  end

`ifndef SYNTHESIS
  req_held_in_calc: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == CALC && !bus.flush_i) |-> req[owner]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// tb_muldiv_sched: scoreboard bench for muldiv_sched with a plain-arithmetic RV32M reference.
module tb_muldiv_sched;
  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  logic [31:0] last_r0 = '0;
  logic [31:0] last_r1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  muldiv_sched_if #(.XLEN(XLEN)) bus ();
  muldiv_sched #(.XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expectation for that slot
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done0_o) begin
        if (q0.size() == 0) check32("done0_unexpected", 32'(bus.done0_o), 32'd0);
        else begin
          e0 = q0.pop_front();
          check32("result0", bus.result0_o, e0.val);
          check_int("done0_cycle", cyc, e0.cyc);
          check32("result1_held", bus.result1_o, last_r1);
          last_r0 = e0.val;
        end
      end
      if (bus.done1_o) begin
        if (q1.size() == 0) check32("done1_unexpected", 32'(bus.done1_o), 32'd0);
        else begin
          e1 = q1.pop_front();
          check32("result1", bus.result1_o, e1.val);
          check_int("done1_cycle", cyc, e1.cyc);
          check32("result0_held", bus.result0_o, last_r0);
          last_r1 = e1.val;
        end
      end
    end
  end

  task automatic issue(input logic r0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic r1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic scramble);
    int t;
    int last;
    @(posedge clk); #1;
    bus.req0_i = r0; bus.op0_i = o0; bus.a0_i = a0; bus.b0_i = b0;
    bus.req1_i = r1; bus.op1_i = o1; bus.a1_i = a1; bus.b1_i = b1;
    t = cyc;
    if (r0) q0.push_back('{model(o0, a0, b0), t + 34});
    if (r1) q1.push_back('{model(o1, a1, b1), r0 ? t + 69 : t + 34});
    last = (r0 && r1) ? t + 69 : t + 34;
    @(negedge clk);
    check32("stall_raise", 32'(bus.stall_o), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (!bus.stall_o) break;
      // Operands already latched by the engine may change freely
      if (scramble && i == 5 && r0) begin
        bus.op0_i = 3'($urandom); bus.a0_i = $urandom; bus.b0_i = $urandom;
      end
      if (scramble && i == 40) begin
        bus.op0_i = 3'($urandom); bus.a0_i = $urandom; bus.b0_i = $urandom;
        bus.op1_i = 3'($urandom); bus.a1_i = $urandom; bus.b1_i = $urandom;
      end
      @(negedge clk);
    end
    check_int("stall_drop_cycle", cyc, last);
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic r0, r1;
    bus.flush_i = 1'b0;
    bus.req0_i = 1'b0; bus.op0_i = 3'd0; bus.a0_i = '0; bus.b0_i = '0;
    bus.req1_i = 1'b0; bus.op1_i = 3'd0; bus.a1_i = '0; bus.b1_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_result0", bus.result0_o, 32'd0);
    check32("reset_result1", bus.result1_o, 32'd0);
    check32("reset_done", {30'd0, bus.done1_o, bus.done0_o}, 32'd0);
    check32("reset_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 3'd0, 0, 0, 0);
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    issue(0, 3'd0, 0, 0, 1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    issue(0, 3'd0, 0, 0, 1, 3'd5, 32'd5, 32'd0, 0);
    issue(0, 3'd0, 0, 0, 1, 3'd7, 32'd5, 32'd0, 0);
    issue(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 0, 0, 0);
    issue(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 0, 0, 0);
    issue(1, 3'd4, 32'hFFFF_FFF9, 32'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 0, 0, 0);

    // Randomized pairs
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      issue(r0, 3'($urandom), rand_operand(), rand_operand(),
            r1, 3'($urandom), rand_operand(), rand_operand(), 1'b1);
    end
    drop_reqs();

    // Flush mid-divide: no pulse, engine idle afterwards
    @(posedge clk); #1;
    bus.req0_i = 1'b1; bus.op0_i = 3'd4; bus.a0_i = 32'd1000; bus.b0_i = 32'd7;
    t = cyc;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    check_int("flush_cycle", cyc, t + 10);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.req0_i = 1'b0;
    @(negedge clk);
    check32("flush_stall_low", 32'(bus.stall_o), 32'd0);
    repeat (40) @(negedge clk);
    check32("flush_result0_kept", bus.result0_o, last_r0);
    issue(1, 3'd5, 32'd1000, 32'd7, 0, 3'd0, 0, 0, 0);
    drop_reqs();

    // Asynchronous reset mid-multiply
    issue(0, 3'd0, 0, 0, 1, 3'd0, 32'd3, 32'd5, 0);
    drop_reqs();
    @(posedge clk); #1;
    bus.req0_i = 1'b1; bus.op0_i = 3'd0; bus.a0_i = 32'd9; bus.b0_i = 32'd9;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check32("arst_result0", bus.result0_o, 32'd0);
    check32("arst_result1", bus.result1_o, 32'd0);
    check32("arst_done", {30'd0, bus.done1_o, bus.done0_o}, 32'd0);
    check32("arst_stall_follows_req", 32'(bus.stall_o), 32'd1);
    bus.req0_i = 1'b0;
    #1 check32("arst_stall_idle", 32'(bus.stall_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_r0 = '0;
    last_r1 = '0;
    issue(1, 3'd1, 32'h4000_0000, 32'd4, 0, 3'd0, 0, 0, 0);
    drop_reqs();

    repeat (5) @(negedge clk);
    check_int("q0_drained", q0.size(), 0);
    check_int("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
